// File: rtl/ula_arb_pkg.sv
// Shared definitions for the two-requester ULA arbiter: FSM states, flag
// positions, default widths and the ULA opcode map.
package ula_arb_pkg;

  localparam int unsigned DW_DEF  = 3;
  localparam int unsigned OPW_DEF = 5;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam logic [OPW_DEF-1:0] OP_ADD  = 5'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB  = 5'd1;
  localparam logic [OPW_DEF-1:0] OP_AND  = 5'd2;
  localparam logic [OPW_DEF-1:0] OP_OR   = 5'd3;
  localparam logic [OPW_DEF-1:0] OP_XOR  = 5'd4;
  localparam logic [OPW_DEF-1:0] OP_NOT  = 5'd5;
  localparam logic [OPW_DEF-1:0] OP_PASS = 5'd6;
  localparam logic [OPW_DEF-1:0] OP_SHL  = 5'd7;
  localparam logic [OPW_DEF-1:0] OP_SHR  = 5'd8;
  localparam logic [OPW_DEF-1:0] OP_INC  = 5'd9;
  localparam logic [OPW_DEF-1:0] OP_DEC  = 5'd10;

endpackage

// File: rtl/ula_arb_ula.sv
// Combinational ULA: result plus {O,C,S,Z}. Unknown opcodes yield zero.
module ula_arb_ula
  import ula_arb_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  resu,
  output logic [3:0]     flg
);

  logic [DW:0] wide;
  logic        cy;
  logic        ov;

  always_comb begin
    wide = '0;
    cy   = 1'b0;
    ov   = 1'b0;
    case (op)
      OPW'(OP_ADD): begin
        wide = {1'b0, a} + {1'b0, b};
        cy   = wide[DW];
        ov   = (a[DW-1] == b[DW-1]) && (wide[DW-1] != a[DW-1]);
      end
      OPW'(OP_SUB): begin
        // carry out here is the borrow (a < b unsigned)
        wide = {1'b0, a} - {1'b0, b};
        cy   = wide[DW];
        ov   = (a[DW-1] != b[DW-1]) && (wide[DW-1] != a[DW-1]);
      end
      OPW'(OP_AND):  wide = {1'b0, a & b};
      OPW'(OP_OR):   wide = {1'b0, a | b};
      OPW'(OP_XOR):  wide = {1'b0, a ^ b};
      OPW'(OP_NOT):  wide = {1'b0, ~a};
      OPW'(OP_PASS): wide = {1'b0, a};
      OPW'(OP_SHL): begin
        wide = {a, 1'b0};
        cy   = a[DW-1];
      end
      OPW'(OP_SHR): begin
        wide = {1'b0, a >> 1};
        cy   = a[0];
      end
      OPW'(OP_INC): begin
        wide = {1'b0, a} + (DW+1)'(1);
        cy   = wide[DW];
        ov   = !a[DW-1] && wide[DW-1];
      end
      OPW'(OP_DEC): begin
        wide = {1'b0, a} - (DW+1)'(1);
        cy   = wide[DW];
        ov   = a[DW-1] && !wide[DW-1];
      end
      default: wide = '0;
    endcase
  end

  always_comb begin
    resu         = wide[DW-1:0];
    flg          = '0;
    flg[FLAG_O]  = ov;
    flg[FLAG_C]  = cy;
    flg[FLAG_S]  = wide[DW-1];
    flg[FLAG_Z]  = (wide[DW-1:0] == '0);
  end

endmodule

// File: rtl/ula_arb.sv
// Round-robin arbiter sharing one ULA between two valid/ready requesters;
// each operation walks IDLE -> ISSUE -> CAPTURE -> RESPOND.
module ula_arb
  import ula_arb_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned OPW  = OPW_DEF,
  parameter int unsigned NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_resu,
  output logic [3:0]          rsp_flags,
  output logic [3:0]          flags,
  output logic                busy
);

  state_t         state;
  logic           ptr;
  logic           owner;
  logic [DW-1:0]  opa;
  logic [DW-1:0]  opb;
  logic [OPW-1:0] opc;

  logic           gnt_any;
  logic           gnt_idx;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  ula_resu;
  logic [3:0]     ula_flg;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      gnt_any = 1'b1;
      gnt_idx = ptr;
    end else if (req_valid[0]) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b0;
    end else if (req_valid[1]) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  always_comb begin
    sel_a  = gnt_idx ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
    sel_b  = gnt_idx ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
    sel_op = gnt_idx ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  end

  // rst_n gates the grant so req_ready drops the instant reset asserts
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == ST_IDLE) && gnt_any)
      req_ready = NREQ'(1) << gnt_idx;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESPOND)
      rsp_valid = NREQ'(1) << owner;
  end

  assign busy = (state != ST_IDLE);

  ula_arb_ula #(
    .DW  (DW),
    .OPW (OPW)
  ) u_ula (
    .a    (opa),
    .b    (opb),
    .op   (opc),
    .resu (ula_resu),
    .flg  (ula_flg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      opc       <= '0;
      rsp_resu  <= '0;
      rsp_flags <= '0;
      flags     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            opa   <= sel_a;
            opb   <= sel_b;
            opc   <= sel_op;
            owner <= gnt_idx;
            ptr   <= ~gnt_idx;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp_resu  <= ula_resu;
          rsp_flags <= ula_flg;
          flags     <= ula_flg;
          state     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready[owner])
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arb.sv
// Directed bench for ula_arb: single op, round-robin, backpressure,
// non-owner ready, reset abort and zero-flag behaviour.
module tb_ula_arb;
  import ula_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_a;
  logic [5:0] req_b;
  logic [9:0] req_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [2:0] rsp_resu;
  logic [3:0] rsp_flags;
  logic [3:0] flags;
  logic       busy;

  int n_cmp;
  int n_err;

  ula_arb #(
    .DW   (3),
    .OPW  (5),
    .NREQ (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_resu  (rsp_resu),
    .rsp_flags (rsp_flags),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [2:0] a,
                         input logic [2:0] b, input logic [4:0] op);
    if (i == 0) begin
      req_a[2:0]  = a;
      req_b[2:0]  = b;
      req_op[4:0] = op;
    end else begin
      req_a[5:3]  = a;
      req_b[5:3]  = b;
      req_op[9:5] = op;
    end
  endtask

  // Called just after a negedge in IDLE with inputs driven; returns at a negedge.
  task automatic run_op(input string tag, input logic [1:0] exp_gnt,
                        input logic [2:0] exp_res, input logic [3:0] exp_flg);
    #1;
    chk({tag, "_grant"}, req_ready, exp_gnt);
    @(posedge clk); #1;
    chk({tag, "_issue_busy"}, busy, 1);
    chk({tag, "_issue_rdy"}, req_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_cap_busy"}, busy, 1);
    chk({tag, "_cap_rspv"}, rsp_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_rsp_busy"}, busy, 1);
    chk({tag, "_rspv"}, rsp_valid, exp_gnt);
    chk({tag, "_resu"}, rsp_resu, exp_res);
    chk({tag, "_rflg"}, rsp_flags, exp_flg);
    chk({tag, "_flags"}, flags, exp_flg);
    @(posedge clk); #1;
    chk({tag, "_done_rspv"}, rsp_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b00;

    // Reset state, with both requests asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_resu", rsp_resu, 0);
    chk("rst_rflg", rsp_flags, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single request: 3 + 2 = 5 -> {O,C,S,Z} = 1010.
    @(negedge clk);
    set_req(0, 3'd3, 3'd2, OP_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    run_op("single", 2'b01, 3'd5, 4'b1010);
    req_valid = 2'b00;
    #1;
    chk("single_idle_busy", busy, 0);

    // Requester 1: 4 - 4 = 0 -> Z; requester 0 arrives while stalled.
    @(negedge clk);
    set_req(1, 3'd4, 3'd4, OP_SUB);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    chk("bp_grant", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 3'd1, 3'd1, OP_ADD);
    req_valid = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    chk("bp_rspv", rsp_valid, 2'b10);
    chk("bp_resu", rsp_resu, 3'd0);
    chk("bp_rflg_z", rsp_flags, 4'b0001);
    chk("bp_flags_z", flags, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_rspv", i), rsp_valid, 2'b10);
      chk($sformatf("bp_hold%0d_resu", i), rsp_resu, 3'd0);
      chk($sformatf("bp_hold%0d_rdy", i), req_ready, 2'b00);
      chk($sformatf("bp_hold%0d_flags", i), flags, 4'b0001);
    end
    @(negedge clk);
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    chk("bp_rel_rspv", rsp_valid, 0);
    chk("bp_rel_grant", req_ready, 2'b01);
    chk("bp_rel_flags", flags, 4'b0001);
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    run_op("stall_serve", 2'b01, 3'd2, 4'b0000);
    req_valid = 2'b00;

    // Round-robin after reset with both requests held.
    rst_n = 1'b0;
    set_req(0, 3'd6, 3'd3, OP_AND);
    set_req(1, 3'd5, 3'd5, OP_XOR);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("rr0", 2'b01, 3'd2, 4'b0000);
    run_op("rr1", 2'b10, 3'd0, 4'b0001);
    set_req(0, 3'd1, 3'd2, OP_SUB);
    run_op("rr2", 2'b01, 3'd7, 4'b0110);

    // Reset asserted during CAPTURE aborts the operation.
    set_req(0, 3'd1, 3'd2, OP_ADD);
    req_valid = 2'b01;
    #1;
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_in_cap", rsp_valid, 0);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("abort_resu", rsp_resu, 0);
    chk("abort_rflg", rsp_flags, 0);
    chk("abort_flags", flags, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rspv", rsp_valid, 0);
    chk("abort_rdy", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_rspv", i), rsp_valid, 0);
      chk($sformatf("post_rst%0d_busy", i), busy, 0);
    end
    @(negedge clk);
    req_valid = 2'b01;
    run_op("post_rst", 2'b01, 3'd3, 4'b0000);
    req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
